// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
//   state_e   : pass-level FSM states
//   BYTE_W    : width of one bitstream byte
//   num_bytes : ceil(chain_len / BYTE_W), the number of bytes one pass consumes
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StVerify,
        StDone
    } state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned num_bytes(input int unsigned chain_len);
        return (chain_len + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// One-byte buffer that turns a valid/ready byte stream into an LSB-first bit stream.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   en_i           : a pass is active (LOAD or VERIFY)
//   flush_i        : drop the buffered byte and reset the byte counter
//   s_data_i/s_valid_i/s_ready_o : byte stream in
//   head_o         : current serial bit (holds the last shifted bit when starved)
//   shift_en_o     : a bit is presented and consumed this cycle
module ccff_byte_serializer
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic [BYTE_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              head_o,
    output logic              shift_en_o
);

    localparam int unsigned NumBytes = num_bytes(CHAIN_LEN);
    localparam int unsigned BW       = $clog2(NumBytes + 1);
    localparam int unsigned IW       = $clog2(BYTE_W);

    logic [BYTE_W-1:0] buf_q, buf_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              vld_q, vld_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic              head_q, head_d;

    logic shift, ready, accept, last_bit;

    assign shift    = en_i & vld_q;
    assign last_bit = (idx_q == IW'(BYTE_W - 1));
    // Refill when empty or when the final bit leaves this cycle; never past the chain length.
    assign ready    = en_i & (cnt_q < BW'(NumBytes)) & (~vld_q | last_bit);
    assign accept   = s_valid_i & ready;

    always_comb begin
        buf_d  = buf_q;
        idx_d  = idx_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (shift) begin
            head_d = buf_q[idx_q];
            idx_d  = idx_q + IW'(1);
            if (last_bit) begin
                vld_d = 1'b0;
            end
        end
        if (accept) begin
            buf_d = s_data_i;
            idx_d = '0;
            vld_d = 1'b1;
            cnt_d = cnt_q + BW'(1);
        end
        // Flush wins: discards unused upper bits of the final byte.
        if (flush_i) begin
            idx_d = '0;
            vld_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q  <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
            head_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            idx_q  <= idx_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    assign s_ready_o  = ready;
    assign shift_en_o = shift;
    assign head_o     = vld_q ? buf_q[idx_q] : head_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads and verifies the I/O tile configuration-flip-flop chain from a byte stream.
//   prog_clk, prog_rst_n          : clock, asynchronous active-low reset
//   start, verify                 : pass command (verify=1 re-streams and compares)
//   s_data, s_valid, s_ready      : bitstream bytes, bit 0 first
//   ccff_head, ccff_shift_en      : serial data and advance enable into the chain
//   ccff_tail                     : chain output, compared during VERIFY
//   busy, done                    : pass in progress / one-cycle end-of-pass pulse
//   err, mismatch_cnt             : verify result (sticky until next start)
//   cfg_done                      : chain holds a valid configuration
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = 64,
    localparam int unsigned CW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              verify,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CW-1:0]     mismatch_cnt,
    output logic              cfg_done
);

    state_e        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] mis_q, mis_d;
    logic          err_q, err_d;
    logic          cfg_q, cfg_d;

    logic start_ok, active, last;

    assign start_ok = start & (state_q == StIdle);
    assign active   = (state_q == StLoad) | (state_q == StVerify);
    assign last     = ccff_shift_en & (bit_cnt_q == CW'(CHAIN_LEN - 1));

    ccff_byte_serializer #(
        .CHAIN_LEN(CHAIN_LEN)
    ) u_ser (
        .clk_i     (prog_clk),
        .rst_ni    (prog_rst_n),
        .en_i      (active),
        .flush_i   (start_ok | last),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .head_o    (ccff_head),
        .shift_en_o(ccff_shift_en)
    );

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:           if (start) state_d = verify ? StVerify : StLoad;
            StLoad, StVerify: if (last) state_d = StDone;
            StDone:           state_d = StIdle;
            default:          state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        mis_d     = mis_q;
        err_d     = err_q;
        cfg_d     = cfg_q;
        if (start_ok) begin
            bit_cnt_d = '0;
            mis_d     = '0;
            err_d     = 1'b0;
            if (!verify) begin
                cfg_d = 1'b0;
            end
        end
        if (ccff_shift_en) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (state_q == StVerify && ccff_tail != ccff_head && mis_q != '1) begin
                mis_d = mis_q + CW'(1);
            end
        end
        // Results land on the final shift edge so they are visible alongside done.
        if (last) begin
            if (state_q == StVerify) begin
                err_d = (mis_d != '0);
                cfg_d = cfg_q & (mis_d == '0);
            end else begin
                cfg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            bit_cnt_q <= '0;
            mis_q     <= '0;
            err_q     <= 1'b0;
            cfg_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
            cfg_q     <= cfg_d;
        end
    end

    assign err          = err_q;
    assign mismatch_cnt = mis_q;
    assign cfg_done     = cfg_q;

endmodule
